mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one external memory bus between the instruction-fetch and data-access requesters.
//  Grants one request at a time and maps its virtual address through the shared address-translation unit.
//  Issues the physical request on the bus, waits for the bus response, and returns the response to the granted requester.
//  Sits between the CPU pipeline memory ports and the bus/cache interface.
// PARAMETERS
//  DATA_W  32        bus/requester data width; STRB_W = DATA_W/8
// PORTS
//  clk               in   1       sole clock, all state on rising edge
//  resetn            in   1       asynchronous, active-low reset
//  ireq_valid        in   1       instruction fetch request
//  ireq_addr         in   32      fetch virtual address
//  ireq_ready        out  1       fetch request accepted (1-cycle pulse)
//  iresp_valid       out  1       fetch data valid (1-cycle pulse)
//  iresp_data        out  DATA_W  fetch data
//  dreq_valid        in   1       data request
//  dreq_addr         in   32      data virtual address
//  dreq_write        in   1       1 = store, 0 = load
//  dreq_size         in   2       0 = byte, 1 = half, 2 = word
//  dreq_strobe       in   STRB_W  store byte enables
//  dreq_wdata        in   DATA_W  store data
//  dreq_ready        out  1       data request accepted (1-cycle pulse)
//  dresp_valid       out  1       load data / store ack (1-cycle pulse)
//  dresp_data        out  DATA_W  load data (bus data passed through on stores)
//  bus_req_valid     out  1       bus request valid
//  bus_req_addr      out  32      physical address
//  bus_req_uncached  out  1       uncached flag from translation
//  bus_req_write     out  1       store
//  bus_req_size      out  2       size (fetch = 2)
//  bus_req_strobe    out  STRB_W  byte enables (fetch = 0)
//  bus_req_wdata     out  DATA_W  store data (fetch = 0)
//  bus_req_ready     in   1       bus accepts request
//  bus_resp_valid    in   1       bus response valid
//  bus_resp_data     in   DATA_W  bus response data
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; captured request cleared; last_grant = instruction.
//  - Requesters hold valid and payload stable until ready pulses. Ready is asserted only in IDLE.
//  - IDLE: if any valid, grant per policy; pulse that requester's ready; capture payload and requester id; go to REQ.
//  - Address: translation acts on the captured vaddr, so bus_req_addr and bus_req_uncached stay stable through REQ.
//  - REQ: bus_req_valid = 1 with the captured payload. On bus_req_ready, go to WAIT. Payload must not change while stalled.
//  - WAIT: on bus_resp_valid, register the data, set the matching resp_valid for the next cycle, go to IDLE.
//  - Latency: request accepted at cycle N -> bus_req_valid at N+1.
//  - Latency: bus_resp_valid at cycle M -> resp_valid at M+1. IDLE at M+1 may accept a new request in the same cycle.
//  - Arbitration, default: data strictly beats instruction when both are valid. Instruction starvation is accepted.
//  - bus_resp_valid in IDLE or REQ is spurious: it is ignored, produces no resp pulse, and causes no state change.
//  - Reset mid-operation: immediate return to IDLE with outputs 0. Any in-flight transaction is dropped and never answered.
//  - At most one outstanding transaction; the only states are IDLE, REQ and WAIT.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin arbitration. When both requesters are valid, grant the one not equal to last_grant.
//    last_grant updates on every grant.
//  MEM_ARB_RR_EN undefined: fixed data-first priority. No last_grant register is built.
// STRUCTURE
//  - Package mem_arb_pkg: vaddr_t/paddr_t typedefs, arb_state_e (IDLE/REQ/WAIT), req_id_e (INST/DATA).
//  - Package mem_arb_pkg also holds mem_req_t struct {addr, write, size, strobe, wdata}.
//  - Sub-module: one instance of the existing `translation` unit on the captured vaddr. No other sub-modules.
// TESTING
//  1. Fetch-only request, ireq_addr = 0x8000_1000, bus responds with 0xDEADBEEF.
//     -> bus_req_addr = 0x0000_1000, size = 2.
//     -> iresp_valid high for 1 cycle with 0xDEADBEEF; dresp_valid stays 0.
//  2. Store to 0x0040_0010, strobe 4'b1100, wdata 0x1234_5678.
//     -> bus_req_addr = 0x0040_0010, write = 1, strobe and wdata match.
//     -> dresp_valid pulses once.
//  3. ireq and dreq valid in the same cycle, 4 back-to-back transactions.
//     -> default build grants D,D,D,D while dreq stays valid.
//     -> RR build grants D,I,D,I.
//  4. bus_req_ready held low for 5 cycles.
//     -> bus_req_valid and the payload are stable for all 5 cycles; no ready pulses; WAIT is entered on the 6th.
//  5. resetn low during WAIT, then bus_resp_valid after release.
//     -> all outputs 0; state IDLE; no resp pulse.
//  6. bus_resp_valid pulsed while IDLE with no requests.
//     -> no iresp_valid or dresp_valid; next request is handled normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    typedef logic [31:0] vaddr_t;
    typedef logic [31:0] paddr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } req_id_e;

    // Captured request; the address is still virtual, translation happens downstream.
    typedef struct packed {
        vaddr_t                  addr;
        logic                    write;
        logic [1:0]              size;
        logic [ARB_STRB_W-1:0]   strobe;
        logic [ARB_DATA_W-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_translation.sv
// Address translation unit: fixed segment mapping.
//   0x8000_0000-0x9FFF_FFFF : cached window, top three bits stripped
//   0xA000_0000-0xBFFF_FFFF : uncached window, top three bits stripped
//   everything else         : identity map, cached
module translation
    import mem_arb_pkg::*;
(
    input  vaddr_t vaddr_i,
    output paddr_t paddr_o,
    output logic   uncached_o
);

    logic cached_win;
    logic uncached_win;

    assign cached_win   = (vaddr_i[31:29] == 3'b100);
    assign uncached_win = (vaddr_i[31:29] == 3'b101);

    assign paddr_o    = (cached_win || uncached_win) ? {3'b000, vaddr_i[28:0]} : vaddr_i;
    assign uncached_o = uncached_win;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access share one bus,
// one transaction outstanding at a time (IDLE -> REQ -> WAIT -> IDLE).
// Optional feature macro MEM_ARB_RR_EN: round-robin arbitration between the
// two requesters; without it data always wins over instruction fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ireq_valid,
    input  logic [31:0]       ireq_addr,
    output logic              ireq_ready,
    output logic              iresp_valid,
    output logic [DATA_W-1:0] iresp_data,
    input  logic              dreq_valid,
    input  logic [31:0]       dreq_addr,
    input  logic              dreq_write,
    input  logic [1:0]        dreq_size,
    input  logic [STRB_W-1:0] dreq_strobe,
    input  logic [DATA_W-1:0] dreq_wdata,
    output logic              dreq_ready,
    output logic              dresp_valid,
    output logic [DATA_W-1:0] dresp_data,
    output logic              bus_req_valid,
    output logic [31:0]       bus_req_addr,
    output logic              bus_req_uncached,
    output logic              bus_req_write,
    output logic [1:0]        bus_req_size,
    output logic [STRB_W-1:0] bus_req_strobe,
    output logic [DATA_W-1:0] bus_req_wdata,
    input  logic              bus_req_ready,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_resp_data
);

    arb_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    req_id_e           id_q, id_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              iresp_q, iresp_d;
    logic              dresp_q, dresp_d;
    req_id_e           grant_id;
    paddr_t            paddr;
    logic              uncached;

`ifdef MEM_ARB_RR_EN
    req_id_e           last_grant_q;

    // Pick the requester that was not served last when both compete.
    always_comb begin
        grant_id = dreq_valid ? DATA : INST;
        if (ireq_valid && dreq_valid)
            grant_id = (last_grant_q == INST) ? DATA : INST;
    end

    // Remember who won every grant taken in IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_grant_q <= INST;
        else if (state_q == IDLE && (ireq_valid || dreq_valid))
            last_grant_q <= grant_id;
    end
`else
    // Fixed priority: data beats instruction fetch.
    always_comb begin
        grant_id = dreq_valid ? DATA : INST;
    end
`endif

    // Translation sees only the captured address, so the bus address is stable through REQ.
    translation u_translation (
        .vaddr_i    (req_q.addr),
        .paddr_o    (paddr),
        .uncached_o (uncached)
    );

    // Next-state, request capture and ready pulses.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        id_d       = id_q;
        rdata_d    = rdata_q;
        iresp_d    = 1'b0;
        dresp_d    = 1'b0;
        ireq_ready = 1'b0;
        dreq_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (ireq_valid || dreq_valid) begin
                    id_d    = grant_id;
                    state_d = REQ;
                    if (grant_id == DATA) begin
                        dreq_ready = 1'b1;
                        req_d = '{addr: dreq_addr, write: dreq_write, size: dreq_size,
                                  strobe: dreq_strobe, wdata: dreq_wdata};
                    end else begin
                        ireq_ready = 1'b1;
                        req_d = '{addr: ireq_addr, write: 1'b0, size: 2'd2,
                                  strobe: '0, wdata: '0};
                    end
                end
            end
            REQ: begin
                if (bus_req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus_resp_valid) begin
                    rdata_d = bus_resp_data;
                    iresp_d = (id_q == INST);
                    dresp_d = (id_q == DATA);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= '0;
            id_q    <= INST;
            rdata_q <= '0;
            iresp_q <= 1'b0;
            dresp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            iresp_q <= iresp_d;
            dresp_q <= dresp_d;
        end
    end

    // Bus payload is driven only while requesting; zero otherwise.
    assign bus_req_valid    = (state_q == REQ);
    assign bus_req_addr     = bus_req_valid ? paddr        : '0;
    assign bus_req_uncached = bus_req_valid ? uncached     : 1'b0;
    assign bus_req_write    = bus_req_valid ? req_q.write  : 1'b0;
    assign bus_req_size     = bus_req_valid ? req_q.size   : 2'd0;
    assign bus_req_strobe   = bus_req_valid ? req_q.strobe : '0;
    assign bus_req_wdata    = bus_req_valid ? req_q.wdata  : '0;

    assign iresp_valid = iresp_q;
    assign dresp_valid = dresp_q;
    assign iresp_data  = iresp_q ? rdata_q : '0;
    assign dresp_data  = dresp_q ? rdata_q : '0;

endmodule
